// File: rtl/systolic_mm_engine_if.sv
// Operand/result streaming bundle for systolic_mm_engine.
// master = the operand buffer / writeback side, slave = the engine.
interface systolic_mm_engine_if #(
  parameter int N      = 3,
  parameter int DATA_W = 8,
  parameter int ACC_W  = 20,
  parameter int KW     = 6
);
  logic                start;
  logic [KW-1:0]       k_len;
  logic                in_valid;
  logic                in_ready;
  logic [N*DATA_W-1:0] a_col;
  logic [N*DATA_W-1:0] b_row;
  logic                out_valid;
  logic                out_ready;
  logic [N*ACC_W-1:0]  out_row;
  logic                out_last;
  logic                busy;
  logic                done;
  logic                ovf;

  modport master (
    output start, k_len, in_valid, a_col, b_row, out_ready,
    input  in_ready, out_valid, out_row, out_last, busy, done, ovf
  );

  modport slave (
    input  start, k_len, in_valid, a_col, b_row, out_ready,
    output in_ready, out_valid, out_row, out_last, busy, done, ovf
  );
endinterface

// File: rtl/systolic_mm_engine.sv
// Output-stationary N x N systolic matrix-multiply engine, C = A*B.
// Optional macro SYSTOLIC_SAT_EN: saturating accumulators with sticky ovf;
// without it accumulators wrap and ovf stays 0.

// One multiply-accumulate cell; holds C[i][j] in place.
module systolic_mm_pe #(
  parameter int DATA_W = 8,
  parameter int ACC_W  = 20,
  parameter int SIGNED = 0
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              step,
  input  logic              clr,
  input  logic [DATA_W-1:0] a,
  input  logic [DATA_W-1:0] b,
  output logic [ACC_W-1:0]  acc,
  output logic              ovf_evt
);
  logic [ACC_W-1:0] ext;
  logic [ACC_W-1:0] nxt;
  logic             clamp;

  if (SIGNED != 0) begin : g_sgn
    logic [2*DATA_W-1:0] p;
    assign p   = $signed({{DATA_W{a[DATA_W-1]}}, a}) * $signed({{DATA_W{b[DATA_W-1]}}, b});
    assign ext = {{(ACC_W-2*DATA_W){p[2*DATA_W-1]}}, p};
  end else begin : g_uns
    logic [2*DATA_W-1:0] p;
    assign p   = {{DATA_W{1'b0}}, a} * {{DATA_W{1'b0}}, b};
    assign ext = {{(ACC_W-2*DATA_W){1'b0}}, p};
  end

`ifdef SYSTOLIC_SAT_EN
  logic [ACC_W:0] sum_w;
  assign sum_w = {1'b0, acc} + {1'b0, ext};

  // Clamp at the representable bound instead of wrapping.
  always_comb begin
    nxt   = sum_w[ACC_W-1:0];
    clamp = 1'b0;
    if (SIGNED != 0) begin
      if (acc[ACC_W-1] == ext[ACC_W-1] && sum_w[ACC_W-1] != acc[ACC_W-1]) begin
        clamp = 1'b1;
        nxt   = acc[ACC_W-1] ? {1'b1, {(ACC_W-1){1'b0}}} : {1'b0, {(ACC_W-1){1'b1}}};
      end
    end else if (sum_w[ACC_W]) begin
      clamp = 1'b1;
      nxt   = '1;
    end
  end
`else
  assign nxt   = acc + ext;
  assign clamp = 1'b0;
`endif

  assign ovf_evt = step & clamp;

  // Accumulate only on array steps so input stalls freeze the result.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset)    acc <= '0;
    else if (clr)  acc <= '0;
    else if (step) acc <= nxt;
  end
endmodule

module systolic_mm_engine #(
  parameter int N      = 3,
  parameter int DATA_W = 8,
  parameter int K_MAX  = 16,
  parameter int ACC_W  = 2*DATA_W + $clog2(K_MAX),
  parameter int SIGNED = 0,
  parameter int KW     = $clog2(K_MAX+1) + 1
) (
  input logic                 clk,
  input logic                 reset,
  systolic_mm_engine_if.slave bus
);
  localparam int FW = $clog2(2*N);
  localparam int RW = $clog2(N);

  typedef enum logic [1:0] {IDLE, FEED, FLUSH, DRAIN} state_t;
  state_t state, nstate;

  logic [KW-1:0] klen, kcnt;
  logic [FW-1:0] fcnt;
  logic [RW-1:0] row;
  logic          go, hs_in, hs_out, step, last_row;

  logic [N-1:0][DATA_W-1:0]         a_src, b_src, a_sk, b_sk;
  logic [N-1:0][N-1:0][DATA_W-1:0]  a_in, b_in;
  logic [N-1:0][N-2:0][DATA_W-1:0]  a_pipe;
  logic [N-2:0][N-1:0][DATA_W-1:0]  b_pipe;
  logic [N-1:0][N-1:0][ACC_W-1:0]   acc;
  logic [N-1:0][N-1:0]              pe_ovf;

  assign go       = (state == IDLE) && bus.start;
  assign hs_in    = (state == FEED) && bus.in_valid;
  assign hs_out   = (state == DRAIN) && bus.out_ready;
  assign step     = hs_in || (state == FLUSH);
  assign last_row = (row == RW'(N-1));

  // Zero operands outside FEED so FLUSH pushes bubbles through the skew.
  assign a_src = (state == FEED) ? bus.a_col : '0;
  assign b_src = (state == FEED) ? bus.b_row : '0;

  // State register.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= IDLE;
    else        state <= nstate;
  end

  // Next-state logic.
  always_comb begin
    nstate = state;
    case (state)
      IDLE:  if (bus.start) nstate = (bus.k_len == '0) ? DRAIN : FEED;
      FEED:  if (hs_in && kcnt == klen - KW'(1)) nstate = FLUSH;
      FLUSH: if (fcnt == FW'(2*N-2)) nstate = DRAIN;
      DRAIN: if (hs_out && last_row) nstate = IDLE;
      default: nstate = IDLE;
    endcase
  end

  // Output decode; out_row reads the stationary accumulators of row r.
  always_comb begin
    bus.in_ready  = (state == FEED);
    bus.out_valid = (state == DRAIN);
    bus.out_last  = (state == DRAIN) && last_row;
    bus.busy      = (state != IDLE);
    bus.out_row   = (state == DRAIN) ? acc[row] : '0;
  end

  // Job counters, done pulse and sticky overflow.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      klen <= '0; kcnt <= '0; fcnt <= '0; row <= '0;
      bus.done <= 1'b0; bus.ovf <= 1'b0;
    end else begin
      if (go) begin
        klen <= bus.k_len; kcnt <= '0; fcnt <= '0; row <= '0;
      end
      if (hs_in)            kcnt <= kcnt + KW'(1);
      if (state == FLUSH)   fcnt <= fcnt + FW'(1);
      if (hs_out)           row  <= last_row ? '0 : row + RW'(1);
      bus.done <= hs_out && last_row;
      bus.ovf  <= go ? 1'b0 : (bus.ovf | (|pe_ovf));
    end
  end

  // Input skew: lane i is delayed i steps before entering the array.
  for (genvar gi = 0; gi < N; gi++) begin : g_skew
    if (gi == 0) begin : g_d0
      assign a_sk[0] = a_src[0];
      assign b_sk[0] = b_src[0];
    end else begin : g_dn
      logic [gi-1:0][DATA_W-1:0] ad, bd;
      // Per-lane delay line, advanced only on array steps.
      always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
          ad <= '0; bd <= '0;
        end else if (go) begin
          ad <= '0; bd <= '0;
        end else if (step) begin
          ad[0] <= a_src[gi];
          bd[0] <= b_src[gi];
          for (int d = 1; d < gi; d++) begin
            ad[d] <= ad[d-1];
            bd[d] <= bd[d-1];
          end
        end
      end
      assign a_sk[gi] = ad[gi-1];
      assign b_sk[gi] = bd[gi-1];
    end
  end

  // PE grid: a enters from the left edge, b from the top edge.
  for (genvar gi = 0; gi < N; gi++) begin : g_row
    for (genvar gj = 0; gj < N; gj++) begin : g_col
      if (gj == 0) begin : g_al
        assign a_in[gi][gj] = a_sk[gi];
      end else begin : g_ap
        assign a_in[gi][gj] = a_pipe[gi][gj-1];
      end
      if (gi == 0) begin : g_bt
        assign b_in[gi][gj] = b_sk[gj];
      end else begin : g_bp
        assign b_in[gi][gj] = b_pipe[gi-1][gj];
      end
      systolic_mm_pe #(.DATA_W(DATA_W), .ACC_W(ACC_W), .SIGNED(SIGNED)) u_pe (
        .clk(clk), .reset(reset), .step(step), .clr(go),
        .a(a_in[gi][gj]), .b(b_in[gi][gj]),
        .acc(acc[gi][gj]), .ovf_evt(pe_ovf[gi][gj])
      );
    end
  end

  // Operand forwarding: a moves right, b moves down, one register per hop.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      a_pipe <= '0; b_pipe <= '0;
    end else if (go) begin
      a_pipe <= '0; b_pipe <= '0;
    end else if (step) begin
      for (int i = 0; i < N; i++)
        for (int j = 0; j < N-1; j++)
          a_pipe[i][j] <= a_in[i][j];
      for (int i = 0; i < N-1; i++)
        for (int j = 0; j < N; j++)
          b_pipe[i][j] <= b_in[i][j];
    end
  end
endmodule

// File: tb/tb_systolic_mm_engine.sv
// Bench for systolic_mm_engine: unsigned and signed instances share one
// stimulus stream; each is checked against a plain-arithmetic matrix model.
module tb_systolic_mm_engine;
  localparam int N  = 3;
  localparam int DW = 8;
  localparam int AW = 20;
  localparam int KW = 6;
  localparam int KM = 20;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;

  systolic_mm_engine_if #(.N(N), .DATA_W(DW), .ACC_W(AW), .KW(KW)) u_if ();
  systolic_mm_engine_if #(.N(N), .DATA_W(DW), .ACC_W(AW), .KW(KW)) s_if ();

  logic            start, in_valid, out_ready;
  logic [KW-1:0]   k_len;
  logic [N*DW-1:0] a_col, b_row;

  assign u_if.start = start;     assign s_if.start = start;
  assign u_if.k_len = k_len;     assign s_if.k_len = k_len;
  assign u_if.in_valid = in_valid;   assign s_if.in_valid = in_valid;
  assign u_if.a_col = a_col;     assign s_if.a_col = a_col;
  assign u_if.b_row = b_row;     assign s_if.b_row = b_row;
  assign u_if.out_ready = out_ready; assign s_if.out_ready = out_ready;

  systolic_mm_engine #(.N(N), .DATA_W(DW), .K_MAX(16), .SIGNED(0)) dut_u (
    .clk(clk), .reset(reset), .bus(u_if.slave));
  systolic_mm_engine #(.N(N), .DATA_W(DW), .K_MAX(16), .SIGNED(1)) dut_s (
    .clk(clk), .reset(reset), .bus(s_if.slave));

  logic [DW-1:0] am [N][KM];
  logic [DW-1:0] bm [KM][N];

  task automatic chk(string tag, logic [63:0] obs, logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s obs=%0h exp=%0h", tag, obs, exp);
    end
  endtask

  // C[r][c] from the dot-product definition; clamping applied per addition.
  function automatic logic [AW-1:0] ref_elem(bit sgn, int k, int r, int c, inout bit ov);
    longint acc, p, hi, lo;
    acc = 0;
    hi  = sgn ? (64'sd1 <<< (AW-1)) - 1 : (64'sd1 <<< AW) - 1;
    lo  = sgn ? -(64'sd1 <<< (AW-1)) : 0;
    for (int t = 0; t < k; t++) begin
      if (sgn) p = longint'($signed(am[r][t])) * longint'($signed(bm[t][c]));
      else     p = longint'(am[r][t]) * longint'(bm[t][c]);
      acc += p;
`ifdef SYSTOLIC_SAT_EN
      if (acc > hi) begin acc = hi; ov = 1'b1; end
      if (acc < lo) begin acc = lo; ov = 1'b1; end
`else
      if (hi == lo) ov = 1'b1;
`endif
    end
    return acc[AW-1:0];
  endfunction

  task automatic set_identity();
    for (int i = 0; i < N; i++)
      for (int t = 0; t < KM; t++) begin
        am[i][t] = (t < N && i == t) ? 8'd1 : 8'd0;
        bm[t][i] = (t < N) ? DW'(t*N + i + 1) : 8'd0;
      end
  endtask

  task automatic set_const(logic [DW-1:0] av, logic [DW-1:0] bv);
    for (int i = 0; i < N; i++)
      for (int t = 0; t < KM; t++) begin
        am[i][t] = av; bm[t][i] = bv;
      end
  endtask

  task automatic set_random();
    for (int i = 0; i < N; i++)
      for (int t = 0; t < KM; t++) begin
        am[i][t] = DW'($urandom); bm[t][i] = DW'($urandom);
      end
  endtask

  task automatic run_job(string nm, int k, bit gap, int stall_row, int stall_n);
    logic [N*AW-1:0] eu [N];
    logic [N*AW-1:0] es [N];
    bit ovu, ovs, tog;
    int beat, guard, cnt;
    ovu = 1'b0; ovs = 1'b0;
    for (int r = 0; r < N; r++)
      for (int c = 0; c < N; c++) begin
        eu[r][c*AW +: AW] = ref_elem(1'b0, k, r, c, ovu);
        es[r][c*AW +: AW] = ref_elem(1'b1, k, r, c, ovs);
      end
    @(negedge clk); start = 1'b1; k_len = KW'(k);
    @(negedge clk); start = 1'b0;
    chk({nm, " busy"}, 64'(u_if.busy & s_if.busy), 64'd1);
    beat = 0; guard = 0; tog = 1'b0;
    while (beat < k && guard < 400) begin
      in_valid = gap ? tog : 1'b1;
      tog = ~tog;
      for (int i = 0; i < N; i++) begin
        a_col[i*DW +: DW] = in_valid ? am[i][beat] : DW'($urandom);
        b_row[i*DW +: DW] = in_valid ? bm[beat][i] : DW'($urandom);
      end
      if (in_valid) chk({nm, " in_ready"}, 64'(u_if.in_ready & s_if.in_ready), 64'd1);
      @(negedge clk);
      if (in_valid) beat++;
      guard++;
    end
    in_valid = 1'b0;
    a_col = N*DW'($urandom); b_row = N*DW'($urandom);
    cnt = 1;
    while (!u_if.out_valid && cnt < 60) begin
      @(negedge clk); cnt++;
    end
    chk({nm, " latency"}, 64'(cnt), (k == 0) ? 64'd1 : 64'(2*N));
    for (int r = 0; r < N; r++) begin
      chk($sformatf("%s u_row%0d", nm, r), 64'(u_if.out_row), 64'(eu[r]));
      chk($sformatf("%s s_row%0d", nm, r), 64'(s_if.out_row), 64'(es[r]));
      chk($sformatf("%s last%0d", nm, r), 64'({u_if.out_last, s_if.out_last}),
          (r == N-1) ? 64'd3 : 64'd0);
      if (r == stall_row) begin
        out_ready = 1'b0;
        repeat (stall_n) begin
          @(negedge clk);
          chk($sformatf("%s stall_row%0d", nm, r), 64'(u_if.out_row), 64'(eu[r]));
          chk($sformatf("%s stall_vld%0d", nm, r), 64'(u_if.out_valid), 64'd1);
        end
        out_ready = 1'b1;
      end
      @(negedge clk);
    end
    chk({nm, " done"}, 64'({u_if.done, s_if.done}), 64'd3);
    chk({nm, " idle"}, 64'({u_if.busy, s_if.busy, u_if.out_valid}), 64'd0);
    chk({nm, " u_ovf"}, 64'(u_if.ovf), 64'(ovu));
    chk({nm, " s_ovf"}, 64'(s_if.ovf), 64'(ovs));
    @(negedge clk);
    chk({nm, " done_pulse"}, 64'({u_if.done, s_if.done}), 64'd0);
  endtask

  task automatic chk_zero(string nm);
    chk({nm, " ctl"}, 64'({u_if.in_ready, u_if.out_valid, u_if.out_last, u_if.busy,
                          u_if.done, u_if.ovf, s_if.busy, s_if.in_ready}), 64'd0);
    chk({nm, " rows"}, 64'(u_if.out_row | s_if.out_row), 64'd0);
  endtask

  initial begin
    reset = 1'b0; start = 1'b0; k_len = '0; in_valid = 1'b0; out_ready = 1'b1;
    a_col = '0; b_row = '0;
    #1 chk_zero("reset");
    @(negedge clk); reset = 1'b1;

    set_identity();
    run_job("ident", 3, 1'b0, -1, 0);
    run_job("bpress", 3, 1'b1, 1, 5);

    set_const(8'd255, 8'd255);
    run_job("max16", 16, 1'b0, -1, 0);
    run_job("max17", 17, 1'b0, 0, 2);

    set_const(8'h80, 8'd127);
    run_job("signed", 2, 1'b0, -1, 0);

    run_job("k0", 0, 1'b0, -1, 0);

    // Abort a job mid-FEED with reset, then rerun a clean job.
    set_identity();
    @(negedge clk); start = 1'b1; k_len = KW'(3);
    @(negedge clk); start = 1'b0; in_valid = 1'b1;
    for (int i = 0; i < N; i++) begin
      a_col[i*DW +: DW] = 8'd77; b_row[i*DW +: DW] = 8'd99;
    end
    repeat (2) @(negedge clk);
    reset = 1'b0; in_valid = 1'b0;
    #1 chk_zero("midreset");
    @(negedge clk); reset = 1'b1;
    run_job("ident2", 3, 1'b0, 2, 1);

    for (int n = 0; n < 6; n++) begin
      set_random();
      run_job($sformatf("rand%0d", n), int'($urandom_range(1, KM)), 1'($urandom),
              int'($urandom_range(0, N)), int'($urandom_range(1, 3)));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
